// File: rtl/serial_sub_pkg.sv
// ============================================================================
//  Module   : serial_sub_pkg
//  Brief    : Shared types and constants for the bit-serial subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    // Default operand width used when the parent does not override WIDTH
    localparam int SUB_DEFAULT_WIDTH = 8;

    // Controller states: wait for operands, shift bits, present result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
//  Module   : full_subtractor
//  Brief    : Combinational one-bit full subtractor cell (a - b - bin).
//             Usable stand-alone by any datapath needing a borrow chain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated by this bit position
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Bit-serial two's-complement subtractor computing a - b - bin,
//             LSB first, one bit per clock with a single borrow flop.
//             Valid/ready handshake on both operand and result sides.
//  Config   : define SERIAL_SUB_OVF_EN to register the signed overflow flag;
//             otherwise ovf is tied low and no overflow logic exists.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    // Bit counter needs at least one bit even for the smallest WIDTH
    localparam int              c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    sub_state_t          r_state;
    logic [WIDTH-1:0]    r_sa;
    logic [WIDTH-1:0]    r_sb;
    logic                r_br;
    // Only WIDTH-1 accumulated bits are kept: the newest bit comes straight
    // from the cell, and the oldest would be shifted out on the final cycle.
    logic [WIDTH-2:0]    r_res;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_dbit;
    logic                w_bout;
    logic [WIDTH-1:0]    w_res_next;

    // One full-subtractor cell processes the current LSB pair and borrow
    full_subtractor u_bit (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .bin  (r_br),
        .d    (w_dbit),
        .bout (w_bout)
    );

    // Result after inserting this cycle's difference bit from the MSB side
    assign w_res_next = {w_dbit, r_res};

    // Controller, operand shifters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sa      <= '0;
            r_sb      <= '0;
            r_br      <= 1'b0;
            r_res     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_br     <= bin;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= RUN;
                    end
                end

                RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_br  <= w_bout;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        // Final bit: the remaining operand bits are the MSBs
                        d         <= w_res_next;
                        bout      <= w_bout;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= (r_sa[0] != r_sb[0]) & (w_dbit != r_sa[0]);
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_SUB_OVF_EN
    // Overflow reporting disabled in this build
    assign ovf = 1'b0;
`endif

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Self-checking bench for serial_subtractor (WIDTH = 8) using a
//             scoreboard queue filled at operand acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t_acc    = 0;
    exp_t sb_q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: unsigned 9-bit subtraction for d/bout, signed range for ovf
    function automatic exp_t model(input logic [WIDTH-1:0] a_i,
                                   input logic [WIDTH-1:0] b_i,
                                   input logic             bin_i);
        exp_t         e;
        logic [WIDTH:0] u;
        int           s;
        u      = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, bin_i};
        e.d    = u[WIDTH-1:0];
        e.bout = u[WIDTH];
        s      = int'($signed(a_i)) - int'($signed(b_i)) - (bin_i ? 1 : 0);
`ifdef SERIAL_SUB_OVF_EN
        e.ovf  = (s > 127) || (s < -128);
`else
        e.ovf  = (s > 1000);
`endif
        return e;
    endfunction

    // Present operands at a negedge, wait for in_ready, push expectation
    task automatic send(input logic [WIDTH-1:0] a_i,
                        input logic [WIDTH-1:0] b_i,
                        input logic             bin_i);
        int k = 0;
        a = a_i; b = b_i; bin = bin_i; in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        sb_q.push_back(model(a_i, b_i, bin_i));
        @(negedge clk);
        in_valid = 1'b0;
        t_acc    = cyc;
    endtask

    // Wait for the result, check latency and values, then hand it off
    task automatic recv();
        int   k = 0;
        exp_t e;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL recv_timeout: out_valid=%b required 1", out_valid);
        end
        // DONE is the WIDTH+1-th cycle counting the accept cycle as 0
        n_checks++;
        if (k != WIDTH) begin
            n_fail++;
            $display("FAIL latency: %0d edges required %0d", k, WIDTH);
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: size=0 required >0");
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (d !== e.d) begin
                n_fail++;
                $display("FAIL d: got %h required %h", d, e.d);
            end
            n_checks++;
            if (bout !== e.bout) begin
                n_fail++;
                $display("FAIL bout: got %b required %b", bout, e.bout);
            end
            n_checks++;
            if (ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL ovf: got %b required %b", ovf, e.ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || d !== 8'h00 ||
            bout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b d=%h bout=%b ovf=%b required 0/0/00/0/0",
                     in_ready, out_valid, d, bout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        send(8'h05, 8'h03, 1'b0); recv();
        send(8'h03, 8'h05, 1'b0); recv();
        send(8'h00, 8'h00, 1'b1); recv();
        send(8'h80, 8'h01, 1'b0); recv();
        send(8'h37, 8'h37, 1'b1); recv();
        send(8'h7F, 8'hFF, 1'b0); recv();
    endtask

    task automatic test_backpressure();
        int   k = 0;
        exp_t e;
        send(8'h5A, 8'h3C, 1'b1);
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== e.d ||
                bout !== e.bout || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL hold_%0d: out_valid=%b in_ready=%b d=%h bout=%b ovf=%b required 1/0/%h/%b/%b",
                         i, out_valid, in_ready, d, bout, ovf, e.d, e.bout, e.ovf);
            end
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            in_valid = ~in_valid;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
        repeat (WIDTH + 3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_queue: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        send(8'h55, 8'h22, 1'b0);
        e = sb_q.pop_back();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || d !== 8'h00 || bout !== 1'b0 ||
            ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: out_valid=%b d=%h bout=%b ovf=%b in_ready=%b required 0/00/0/0/0 (discarded %h)",
                     out_valid, d, bout, ovf, in_ready, e.d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_release: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
        send(8'h10, 8'h01, 1'b0);
        recv();
    endtask

    task automatic test_back_to_back();
        int prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            if (i > 0) begin
                n_checks++;
                if (t_acc - prev != WIDTH + 2) begin
                    n_fail++;
                    $display("FAIL init_interval_%0d: %0d cycles required %0d",
                             i, t_acc - prev, WIDTH + 2);
                end
            end
            prev = t_acc;
            recv();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor

`default_nettype wire
